pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised fetch program counter for the RV32I core. Replaces the single-register PC.
//  Adds:
//   - a post-reset hold window;
//   - a fetch request/acknowledge handshake to instruction memory;
//   - a prioritised next-PC select: trap > redirect > sequential;
//   - misaligned-target detection, exception PC capture and a retired-fetch counter.
//  Sits between control unit / branch logic and the instruction memory port.
// PARAMETERS
//  XLEN          32              PC / address width in bits
//  RESET_VECTOR  32'h0100_0000   PC value loaded by reset
//  TRAP_VECTOR   32'h0100_0100   PC loaded on trap or misaligned redirect
//  INSTR_BYTES   4               sequential increment; power of two
//  HOLD_CYCLES   2               cycles with fetch_req=0 after reset release; must be >=1
//  CNT_W         32              width of fetch_cnt
// PORTS
//  clk              in   1       clock, rising edge
//  rst              in   1       reset, synchronous, active-low
//  stall            in   1       freeze PC; no pc_update
//  redirect_valid   in   1       branch/jump taken this cycle
//  redirect_target  in   XLEN    branch/jump destination
//  trap_req         in   1       synchronous exception/ecall; go to TRAP_VECTOR
//  fetch_ack        in   1       imem accepted fetch_addr this cycle
//  fetch_req        out  1       fetch request valid
//  fetch_addr       out  XLEN    address presented to imem (= pc)
//  pc               out  XLEN    current PC
//  pc_next_seq      out  XLEN    pc + INSTR_BYTES; combinational, wraps mod 2^XLEN
//  pc_update        out  1       1-cycle pulse: pc changed on previous edge
//  misalign_err     out  1       1-cycle pulse: misaligned redirect was trapped
//  epc              out  XLEN    PC of faulting fetch; updated on trap or misalign
//  fetch_cnt        out  CNT_W   number of completed PC advances; wraps
// BEHAVIOUR
//  Reset (rst==0 at a rising edge) forces:
//   - pc=RESET_VECTOR, state=HOLD, hold counter=0;
//   - fetch_req=0, pc_update=0, misalign_err=0, epc=0, fetch_cnt=0.
//  Reset has priority over all inputs, including mid-handshake; an outstanding fetch is abandoned.
//  FSM states:
//   - HOLD: fetch_req=0; counts HOLD_CYCLES cycles, then -> FETCH.
//   - FETCH: fetch_req=1, fetch_addr=pc.
//  Advance event (FETCH only) = (fetch_ack & ~stall) | trap_req | redirect_valid. Next PC priority:
//   1 trap_req:
//     - pc<=TRAP_VECTOR, epc<=pc.
//   2 redirect_valid & target[log2(INSTR_BYTES)-1:0]!=0:
//     - pc<=TRAP_VECTOR, epc<=redirect_target, misalign_err<=1.
//   3 redirect_valid:
//     - pc<=redirect_target.
//   4 fetch_ack & ~stall:
//     - pc<=pc_next_seq.
//  Redirect/trap take effect even when stall=1 or fetch_ack=0. The flush overrides the freeze.
//  fetch_ack with stall=1 and no redirect/trap: pc holds; request stays asserted.
//  Every advance:
//   - pc_update<=1 on the same edge; it is 0 in all other cycles;
//   - fetch_cnt<=fetch_cnt+1, wrapping to 0 at all-ones.
//  Inputs are ignored in HOLD. fetch_ack with fetch_req=0 is ignored.
//  Sequential wrap: pc=2^XLEN-INSTR_BYTES advances to 0; no error.
//  Latency: new pc is visible one cycle after the advance edge. fetch_addr tracks pc combinationally.
// STRUCTURE
//  Shared package rv_pkg holds:
//   - localparam XLEN_DEF;
//   - RESET_VECTOR_DEF and TRAP_VECTOR_DEF;
//   - typedef pc_state_e {HOLD, FETCH}.
//  Sub-module pc_next_sel: combinational priority mux plus misalign detect; outputs next_pc and advance flags.
//  Top module holds the state register, pc, epc, counters and pulses.
// TESTING
//  1 Reset: rst=0 for 3 cycles then 1 -> pc=32'h0100_0000, fetch_req=0 for 2 cycles, then fetch_req=1.
//  2 Sequential: ack every cycle for 4 cycles -> pc 0100_0000 -> 0004 -> 0008 -> 000C -> 0010; pc_update=1 each; fetch_cnt=4.
//  3 Stall: stall=1, ack=1 for 3 cycles -> pc frozen, pc_update=0.
//     Then redirect_valid=1, target=0100_0200 with stall=1 -> pc=0100_0200 next cycle.
//  4 Priority: trap_req and redirect_valid in the same cycle at pc=0100_0010 -> pc=0100_0100, epc=0100_0010.
//  5 Misalign: redirect target=0100_0202 -> pc=0100_0100, epc=0100_0202, misalign_err pulses 1 cycle.
//  6 Wrap/reset: pc=FFFF_FFFC, ack -> pc=0000_0000.
//     Then rst=0 while fetch_req=1 -> pc=RESET_VECTOR, fetch_cnt=0, HOLD re-entered.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I fetch front end.
package rv_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0100_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0100_0100;

    // Fetch sequencer states: post-reset quiet window, then continuous fetch.
    typedef enum logic {
        HOLD  = 1'b0,
        FETCH = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > misaligned redirect > redirect > sequential.
// Purely combinational; the caller registers next_pc when o_advance is set.
module pc_next_sel #(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  TRAP_VECTOR = 32'h0100_0100,
    parameter int               INSTR_BYTES = 4
) (
    input  logic            i_is_fetch,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_trap_req,
    input  logic            i_fetch_ack,
    output logic [XLEN-1:0] o_pc_next_seq,
    output logic [XLEN-1:0] o_next_pc,
    output logic            o_advance,
    output logic            o_take_trap,
    output logic            o_take_misalign
);

    // Low address bits that must be zero for an aligned instruction target.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    logic w_misaligned;

    // Sequential successor wraps naturally modulo 2^XLEN.
    assign o_pc_next_seq = i_pc + XLEN'(INSTR_BYTES);
    assign w_misaligned  = |(i_redirect_target & ALIGN_MASK);

    // Select the next PC and classify the advance; flushes override a stall.
    always_comb begin
        o_next_pc       = i_pc;
        o_advance       = 1'b0;
        o_take_trap     = 1'b0;
        o_take_misalign = 1'b0;
        if (i_is_fetch) begin
            if (i_trap_req) begin
                o_next_pc   = TRAP_VECTOR;
                o_advance   = 1'b1;
                o_take_trap = 1'b1;
            end else if (i_redirect_valid && w_misaligned) begin
                o_next_pc       = TRAP_VECTOR;
                o_advance       = 1'b1;
                o_take_misalign = 1'b1;
            end else if (i_redirect_valid) begin
                o_next_pc = i_redirect_target;
                o_advance = 1'b1;
            end else if (i_fetch_ack && !i_stall) begin
                o_next_pc = o_pc_next_seq;
                o_advance = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: post-reset hold window, imem request handshake,
// prioritised next-PC selection, exception PC capture and advance counter.
module pc_unit
    import rv_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int               INSTR_BYTES  = 4,
    parameter int               HOLD_CYCLES  = 2,
    parameter int               CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             trap_req,
    input  logic             fetch_ack,
    output logic             fetch_req,
    output logic [XLEN-1:0]  fetch_addr,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_next_seq,
    output logic             pc_update,
    output logic             misalign_err,
    output logic [XLEN-1:0]  epc,
    output logic [CNT_W-1:0] fetch_cnt
);

    // Hold counter only needs to reach HOLD_CYCLES-1.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    pc_state_e        r_state;
    logic [HW-1:0]    r_hold_cnt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic [CNT_W-1:0] r_fetch_cnt;
    logic             r_pc_update;
    logic             r_misalign;

    logic [XLEN-1:0]  w_next_pc;
    logic             w_advance;
    logic             w_take_trap;
    logic             w_take_misalign;
    logic             w_is_fetch;

    assign w_is_fetch = (r_state == FETCH);

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_next_sel (
        .i_is_fetch        (w_is_fetch),
        .i_pc              (r_pc),
        .i_stall           (stall),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_target (redirect_target),
        .i_trap_req        (trap_req),
        .i_fetch_ack       (fetch_ack),
        .o_pc_next_seq     (pc_next_seq),
        .o_next_pc         (w_next_pc),
        .o_advance         (w_advance),
        .o_take_trap       (w_take_trap),
        .o_take_misalign   (w_take_misalign)
    );

    // Hold window sequencing after reset, then fetch indefinitely.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
        end else if (r_state == HOLD) begin
            if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                r_state <= FETCH;
            end else begin
                r_hold_cnt <= r_hold_cnt + HW'(1);
            end
        end
    end

    // PC, exception PC, advance counter and single-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc        <= RESET_VECTOR;
            r_epc       <= '0;
            r_fetch_cnt <= '0;
            r_pc_update <= 1'b0;
            r_misalign  <= 1'b0;
        end else begin
            r_pc_update <= w_advance;
            r_misalign  <= w_take_misalign;
            if (w_advance) begin
                r_pc        <= w_next_pc;
                r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
            end
            if (w_take_trap) begin
                r_epc <= r_pc;
            end else if (w_take_misalign) begin
                r_epc <= redirect_target;
            end
        end
    end

    assign fetch_req    = w_is_fetch;
    assign fetch_addr   = r_pc;
    assign pc           = r_pc;
    assign pc_update    = r_pc_update;
    assign misalign_err = r_misalign;
    assign epc          = r_epc;
    assign fetch_cnt    = r_fetch_cnt;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with default parameters.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h0100_0000;
    localparam logic [31:0] TV = 32'h0100_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        fetch_ack;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic        pc_update;
    logic        misalign_err;
    logic [31:0] epc;
    logic [31:0] fetch_cnt;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .fetch_ack       (fetch_ack),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .pc              (pc),
        .pc_next_seq     (pc_next_seq),
        .pc_update       (pc_update),
        .misalign_err    (misalign_err),
        .epc             (epc),
        .fetch_cnt       (fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full status snapshot.
    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_upd,
                           input logic e_mis, input logic [31:0] e_epc,
                           input logic [31:0] e_cnt, input logic e_req);
        chk({tag, ".pc"},        pc,                  e_pc);
        chk({tag, ".addr"},      fetch_addr,          e_pc);
        chk({tag, ".upd"},       {31'd0, pc_update},    {31'd0, e_upd});
        chk({tag, ".mis"},       {31'd0, misalign_err}, {31'd0, e_mis});
        chk({tag, ".epc"},       epc,                 e_epc);
        chk({tag, ".cnt"},       fetch_cnt,           e_cnt);
        chk({tag, ".req"},       {31'd0, fetch_req},    {31'd0, e_req});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        trap_req = 1'b0; fetch_ack = 1'b0;

        // Reset held for three edges
        tick(); tick(); tick();
        chk_all("reset", RV, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
        rst = 1'b1;
        fetch_ack = 1'b1;                     // ignored while in HOLD
        chk({"hold0.req"}, {31'd0, fetch_req}, 32'd0);
        tick();
        chk_all("hold1", RV, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
        tick();
        chk_all("fetch_start", RV, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
        chk("seq_nxt0", pc_next_seq, 32'h0100_0004);

        // Sequential fetch, ack every cycle
        tick(); chk_all("seq1", 32'h0100_0004, 1'b1, 1'b0, 32'h0, 32'd1, 1'b1);
        tick(); chk_all("seq2", 32'h0100_0008, 1'b1, 1'b0, 32'h0, 32'd2, 1'b1);
        tick(); chk_all("seq3", 32'h0100_000C, 1'b1, 1'b0, 32'h0, 32'd3, 1'b1);
        tick(); chk_all("seq4", 32'h0100_0010, 1'b1, 1'b0, 32'h0, 32'd4, 1'b1);
        chk("seq_nxt4", pc_next_seq, 32'h0100_0014);

        // Stall with ack: PC frozen, request held
        stall = 1'b1;
        tick(); chk_all("stall1", 32'h0100_0010, 1'b0, 1'b0, 32'h0, 32'd4, 1'b1);
        tick(); chk_all("stall2", 32'h0100_0010, 1'b0, 1'b0, 32'h0, 32'd4, 1'b1);
        tick(); chk_all("stall3", 32'h0100_0010, 1'b0, 1'b0, 32'h0, 32'd4, 1'b1);

        // Redirect overrides stall
        redirect_valid = 1'b1; redirect_target = 32'h0100_0200;
        tick(); chk_all("redir_stall", 32'h0100_0200, 1'b1, 1'b0, 32'h0, 32'd5, 1'b1);

        // No ack, no flush: idle
        redirect_valid = 1'b0; stall = 1'b0; fetch_ack = 1'b0;
        tick(); chk_all("idle", 32'h0100_0200, 1'b0, 1'b0, 32'h0, 32'd5, 1'b1);

        // Position at 0100_0010 via a redirect without ack
        redirect_valid = 1'b1; redirect_target = 32'h0100_0010;
        tick(); chk_all("redir", 32'h0100_0010, 1'b1, 1'b0, 32'h0, 32'd6, 1'b1);

        // Trap beats simultaneous redirect
        trap_req = 1'b1; redirect_target = 32'h0100_0300;
        tick(); chk_all("trap_prio", TV, 1'b1, 1'b0, 32'h0100_0010, 32'd7, 1'b1);
        trap_req = 1'b0;

        // Misaligned redirect traps and pulses misalign_err once
        redirect_target = 32'h0100_0202;
        tick(); chk_all("misalign", TV, 1'b1, 1'b1, 32'h0100_0202, 32'd8, 1'b1);
        redirect_valid = 1'b0;
        tick(); chk_all("misalign_end", TV, 1'b0, 1'b0, 32'h0100_0202, 32'd8, 1'b1);

        // Sequential wrap at top of address space
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick(); chk_all("to_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0100_0202, 32'd9, 1'b1);
        chk("wrap_nxt", pc_next_seq, 32'h0000_0000);
        redirect_valid = 1'b0; fetch_ack = 1'b1;
        tick(); chk_all("wrap", 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0202, 32'd10, 1'b1);

        // Reset mid-request abandons the fetch
        rst = 1'b0;
        tick(); chk_all("rst_mid", RV, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
        rst = 1'b1; trap_req = 1'b1;          // trap ignored during HOLD
        tick(); chk_all("rehold1", RV, 1'b0, 1'b0, 32'h0, 32'd0, 1'b0);
        tick(); chk_all("refetch", RV, 1'b0, 1'b0, 32'h0, 32'd0, 1'b1);
        trap_req = 1'b0;
        tick(); chk_all("post_rst_seq", 32'h0100_0004, 1'b1, 1'b0, 32'h0, 32'd1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
